instruction_iot601x: RTL and testbench
======================================

INSTRUCTION_IOT601X -- requirements
Module: instruction_iot601x

Interface
REQ-001 Parameter READ_DELAY, default 16: clocks from byte acceptance to reader flag set (models reader speed); legal range 0..255.
REQ-002 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 CLEAR  input  1  synchronous clear (CAF / front-panel clear), active-high.
REQ-005 EN  input  1  current instruction is IOT with IR[8:3]=01 (octal).
REQ-006 IR  input  3  IR[2:0] IOT microcode bits.
REQ-007 ck1..ck6  input  1 each  sequencer step pulses, one clock wide, mutually exclusive.
REQ-008 rdr_data  input  8  byte from host reader stream.
REQ-009 rdr_valid  input  1  rdr_data valid.
REQ-010 rdr_ready  output  1  block accepts byte; transfer occurs when rdr_valid & rdr_ready are high on the same rising edge.
REQ-011 ACPTR  output  12  OR-bus contribution to AC, zero when not driving.
REQ-012 rot2ac, ac_ck  output  1 each  AC load path enable and AC clock strobe.
REQ-013 clr  output  1  AC clear request; tied 0 (RRB ORs, never clears).
REQ-014 pc_ck  output  1  PC increment (skip).
REQ-015 done  output  1  instruction complete.
REQ-016 irq  output  1  interrupt request to CPU.

Function
REQ-017 Internal state: flag (1b), ie (1b), buf (8b), shadow (8b), FSM {IDLE, WAIT, DELAY}, delay counter (8b).
REQ-018 All IOT outputs are combinational decodes of EN, IR and ck*, asserted only while EN=1; all zero otherwise.
REQ-019 6010 (IR=000): ie set to 1 at ck1.
REQ-020 RSF, IR[0]=1: pc_ck=1 during ck1 iff flag=1.
REQ-021 RRB, IR[1]=1: during ck2 ACPTR={4'b0,buf}, rot2ac=1, ac_ck=1; flag cleared at the ck2 edge.
REQ-022 RFC, IR[2]=1: at ck3 flag cleared; if FSM=IDLE, FSM -> WAIT; if FSM in WAIT/DELAY, fetch continues unchanged.
REQ-023 Combined codes (6016, 6017) execute each bit's action in ck1/ck2/ck3 order; RRB always returns buffer contents before RFC takes effect.
REQ-024 done=1 during ck6 for any IR value when EN=1 (6013, 6015 included).
REQ-025 FSM WAIT: rdr_ready=1; on transfer, shadow<=rdr_data, counter<=READ_DELAY, FSM -> DELAY.
REQ-026 FSM DELAY: rdr_ready=0; counter decrements each clock; when counter=0, buf<=shadow, flag<=1, FSM -> IDLE; flag visible READ_DELAY+1 clocks after the accepting edge.
REQ-027 FSM IDLE: rdr_ready=0; rdr_valid ignored.
REQ-028 Flag set by FSM and flag clear by RRB/RFC on the same edge: set wins; no character is lost.
REQ-029 irq = flag & ie, combinational.
REQ-030 CLEAR=1: flag<=0, ie<=1, FSM<=IDLE, counter<=0 on that edge; buf and shadow retained; CLEAR overrides all concurrent events.

Reset
REQ-031 RESET_N low asynchronously forces flag=0, ie=1, buf=0, shadow=0, counter=0, FSM=IDLE; hence rdr_ready=0 and irq=0.
REQ-032 Reset mid-fetch abandons the byte; no flag set after release until a new RFC.
REQ-033 All IOT outputs remain zero during reset regardless of ck*/EN.

Verification
REQ-034 Fetch: READ_DELAY=3, 6014 then rdr_data=0x41 valid -> rdr_ready high only in WAIT, flag rises 4 clocks after accept, irq=1.
REQ-035 Read: flag=1, buf=0xC3, execute 6016 -> ck2 ACPTR=0o0303 with rot2ac/ac_ck; flag 0 after ck2; FSM in WAIT after ck3; done at ck6.
REQ-036 Skip: 6011 with flag=0 -> no pc_ck; with flag=1 -> pc_ck exactly during ck1; done at ck6 both cases.
REQ-037 Collision: DELAY counter reaches 0 on same edge as 6012 ck2 -> ACPTR holds old buf, flag ends 1 with new byte in buf.
REQ-038 Clear/reset: CLEAR during DELAY -> FSM IDLE, flag 0, ie 1; RESET_N low during WAIT -> rdr_ready 0 immediately, buf 0.
REQ-039 Disabled: EN=0 with ck1..ck6 pulsing and IR=7 -> all IOT outputs 0, state unchanged.

Source files
------------

// File: rtl/instruction_iot601x.sv
// Paper-tape reader IOT block (device 01).
// Decodes the 601x IOT group and models a reader with a byte buffer, a done flag and a
// fetch FSM that paces incoming bytes by READ_DELAY clocks.
module instruction_iot601x #(
   parameter int unsigned READ_DELAY = 16
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        CLEAR,
   input  logic        EN,
   input  logic [2:0]  IR,
   input  logic        ck1,
   input  logic        ck2,
   input  logic        ck3,
   input  logic        ck4,
   input  logic        ck5,
   input  logic        ck6,
   input  logic [7:0]  rdr_data,
   input  logic        rdr_valid,
   output logic        rdr_ready,
   output logic [11:0] ACPTR,
   output logic        rot2ac,
   output logic        ac_ck,
   output logic        clr,
   output logic        pc_ck,
   output logic        done,
   output logic        irq
);

   localparam logic [7:0] DelayInit = 8'(READ_DELAY);

   typedef enum logic [1:0] {StIdle, StWait, StDelay} state_e;

   state_e      state_q, state_d;
   logic        flag_q, flag_d;
   logic        ie_q, ie_d;
   logic [7:0]  rbuf_q, rbuf_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        iot_act;
   logic        ie_set;
   logic        rsf;
   logic        rrb;
   logic        rfc;
   logic        unused_ck;

   // IOT microcode decode; reset also blanks every IOT output.
   always_comb begin
      iot_act   = EN & RESET_N;
      ie_set    = iot_act & (IR == 3'b000) & ck1;
      rsf       = iot_act & IR[0] & ck1;
      rrb       = iot_act & IR[1] & ck2;
      rfc       = iot_act & IR[2] & ck3;
      unused_ck = ck4 ^ ck5;
   end

   // Combinational IOT outputs and reader status.
   always_comb begin
      pc_ck     = rsf & flag_q;
      rot2ac    = rrb;
      ac_ck     = rrb;
      ACPTR     = rrb ? {4'b0000, rbuf_q} : 12'h000;
      done      = iot_act & ck6;
      clr       = 1'b0;
      irq       = flag_q & ie_q;
      rdr_ready = (state_q == StWait);
   end

   // Next-state: IOT clears first, so a flag set by a completing fetch on the same edge wins;
   // CLEAR is applied last so it overrides everything.
   always_comb begin
      state_d  = state_q;
      flag_d   = flag_q;
      ie_d     = ie_q;
      rbuf_d   = rbuf_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;

      if (ie_set) begin
         ie_d = 1'b1;
      end
      if (rrb || rfc) begin
         flag_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (rfc) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (rdr_valid) begin
               shadow_d = rdr_data;
               cnt_d    = DelayInit;
               state_d  = StDelay;
            end
         end
         StDelay: begin
            if (cnt_q == 8'd0) begin
               rbuf_d  = shadow_q;
               flag_d  = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (CLEAR) begin
         flag_d  = 1'b0;
         ie_d    = 1'b1;
         state_d = StIdle;
         cnt_d   = 8'd0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= StIdle;
         flag_q   <= 1'b0;
         ie_q     <= 1'b1;
         rbuf_q   <= 8'h00;
         shadow_q <= 8'h00;
         cnt_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         flag_q   <= flag_d;
         ie_q     <= ie_d;
         rbuf_q   <= rbuf_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_instruction_iot601x.sv
// Scoreboard bench for instruction_iot601x with READ_DELAY=3.
// Stimulus pushes expected output vectors; the monitor pops and compares on probed cycles.
module tb_instruction_iot601x;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CLEAR = 1'b0;
   logic        EN = 1'b0;
   logic [2:0]  IR = 3'b000;
   logic        ck1 = 1'b0, ck2 = 1'b0, ck3 = 1'b0, ck4 = 1'b0, ck5 = 1'b0, ck6 = 1'b0;
   logic [7:0]  rdr_data = 8'h00;
   logic        rdr_valid = 1'b0;
   logic        rdr_ready;
   logic [11:0] ACPTR;
   logic        rot2ac, ac_ck, clr, pc_ck, done, irq;

   instruction_iot601x #(.READ_DELAY(3)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .CLEAR     (CLEAR),
      .EN        (EN),
      .IR        (IR),
      .ck1       (ck1),
      .ck2       (ck2),
      .ck3       (ck3),
      .ck4       (ck4),
      .ck5       (ck5),
      .ck6       (ck6),
      .rdr_data  (rdr_data),
      .rdr_valid (rdr_valid),
      .rdr_ready (rdr_ready),
      .ACPTR     (ACPTR),
      .rot2ac    (rot2ac),
      .ac_ck     (ac_ck),
      .clr       (clr),
      .pc_ck     (pc_ck),
      .done      (done),
      .irq       (irq)
   );

   always #5 CLK = ~CLK;

   // Vector: {rdr_ready, irq, done, pc_ck, clr, ac_ck, rot2ac, ACPTR[11:0]}
   localparam logic [18:0] MAll = 19'h7FFFF;
   localparam logic [18:0] MIot = 19'h1FFFF;

   typedef struct {
      string       nm;
      logic [18:0] e;
      logic [18:0] m;
   } exp_t;

   exp_t        sb[$];
   logic        probe = 1'b0;
   int          n_vec = 0;
   int          n_bad = 0;
   logic [18:0] act;
   exp_t        ent;

   function automatic logic [18:0] mk(input logic rdy, input logic iq, input logic dn,
                                      input logic pc, input logic rd, input logic [11:0] a);
      return {rdy, iq, dn, pc, 1'b0, rd, rd, a};
   endfunction

   // Monitor: compares the probed cycle's outputs against the oldest expectation.
   always @(negedge CLK) begin
      if (probe) begin
         act = {rdr_ready, irq, done, pc_ck, clr, ac_ck, rot2ac, ACPTR};
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL no_expectation: got %05h want <none>", act);
         end else begin
            ent = sb.pop_front();
            if ((act & ent.m) !== (ent.e & ent.m)) begin
               n_bad++;
               $display("FAIL %s: got %05h want %05h (mask %05h)", ent.nm, act & ent.m,
                        ent.e & ent.m, ent.m);
            end
         end
      end
   end

   task automatic cyc(input logic [6:1] cks, input logic chk, input string nm,
                      input logic [18:0] e, input logic [18:0] m);
      exp_t x;
      {ck6, ck5, ck4, ck3, ck2, ck1} = cks;
      probe = chk;
      if (chk) begin
         x.nm = nm;
         x.e  = e;
         x.m  = m;
         sb.push_back(x);
      end
      @(posedge CLK);
      #1;
      {ck6, ck5, ck4, ck3, ck2, ck1} = 6'b000000;
      probe = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(6'b000000, 1'b0, "", 19'h0, 19'h0);
   endtask

   task automatic status(input string nm, input logic rdy, input logic iq);
      cyc(6'b000000, 1'b1, nm, mk(rdy, iq, 1'b0, 1'b0, 1'b0, 12'h000), MAll);
   endtask

   // Runs ck1..ck6 of one IOT; fl/b/rdy/idl describe the state at ck1 (no reader traffic).
   task automatic iot(input string nm, input logic [2:0] ir, input logic en, input logic fl,
                      input logic [7:0] b, input logic rdy, input logic idl, input logic full);
      logic        f, r, rd;
      logic [6:1]  c;
      EN = en;
      IR = ir;
      for (int k = 1; k <= 6; k++) begin
         f = fl;
         r = rdy;
         if (en && k >= 3 && ir[1]) f = 1'b0;
         if (en && k >= 4 && ir[2]) begin
            f = 1'b0;
            r = rdy | idl;
         end
         rd   = en && (k == 2) && ir[1];
         c    = 6'b000000;
         c[k] = 1'b1;
         cyc(c, 1'b1, $sformatf("%s.ck%0d", nm, k),
             mk(r, f, en && (k == 6), en && (k == 1) && ir[0] && fl, rd,
                rd ? {4'h0, b} : 12'h000),
             full ? MAll : MIot);
      end
      EN = 1'b0;
      IR = 3'b000;
   endtask

   task automatic feed(input string nm, input logic [7:0] d);
      rdr_valid = 1'b1;
      rdr_data  = d;
      status(nm, 1'b1, 1'b0);
      rdr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      @(posedge CLK);
      #1;
      // IOT outputs blanked while held in reset.
      EN = 1'b1;
      IR = 3'b111;
      cyc(6'b000010, 1'b1, "rst_ck2", 19'h0, MAll);
      cyc(6'b100000, 1'b1, "rst_ck6", 19'h0, MAll);
      cyc(6'b000001, 1'b1, "rst_ck1", 19'h0, MAll);
      EN = 1'b0;
      IR = 3'b000;
      RESET_N = 1'b1;
      status("post_rst", 1'b0, 1'b0);

      // Idle ignores the reader.
      rdr_valid = 1'b1;
      rdr_data  = 8'h55;
      status("idle_ign1", 1'b0, 1'b0);
      status("idle_ign2", 1'b0, 1'b0);
      rdr_valid = 1'b0;

      iot("rsf0", 3'b001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // Fetch 0x41: flag 4 clocks after accept.
      iot("rfc1", 3'b100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      status("wait_rdy", 1'b1, 1'b0);
      feed("accept41", 8'h41);
      for (int i = 0; i < 4; i++) status("delay", 1'b0, 1'b0);
      status("flag_set", 1'b0, 1'b1);

      iot("rsf1", 3'b001, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b1);
      iot("6013", 3'b011, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b1);

      // Read 0xC3 with 6016.
      iot("rfc2", 3'b100, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1);
      feed("acceptC3", 8'hC3);
      idle(4);
      status("flag_c3", 1'b0, 1'b1);
      iot("6016", 3'b110, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
      iot("rfc_in_wait", 3'b100, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1);

      // Collision: counter expires on the 6012 ck2 edge.
      feed("accept5A", 8'h5A);
      idle(2);
      iot("coll", 3'b010, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
      status("coll_flag", 1'b0, 1'b1);
      iot("rrb_new", 3'b010, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);

      // CLEAR during DELAY abandons the byte but keeps buf.
      iot("rfc3", 3'b100, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
      feed("accept77", 8'h77);
      CLEAR = 1'b1;
      status("clear", 1'b0, 1'b0);
      CLEAR = 1'b0;
      idle(5);
      status("after_clr", 1'b0, 1'b0);
      iot("rrb_kept", 3'b010, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);

      // 6010 and disabled decode with flag set.
      iot("rfc4", 3'b100, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
      feed("accept3C", 8'h3C);
      idle(4);
      status("flag_3c", 1'b0, 1'b1);
      iot("6010", 3'b000, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
      iot("disabled", 3'b111, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
      status("dis_state", 1'b0, 1'b1);
      iot("rrb_3c", 3'b010, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);

      // Reset during WAIT: ready drops at once, buf cleared, no flag afterwards.
      iot("rfc5", 3'b100, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
      status("wait2", 1'b1, 1'b0);
      RESET_N   = 1'b0;
      rdr_valid = 1'b1;
      rdr_data  = 8'h99;
      EN        = 1'b1;
      IR        = 3'b111;
      cyc(6'b000010, 1'b1, "rst_wait", 19'h0, MAll);
      EN        = 1'b0;
      IR        = 3'b000;
      rdr_valid = 1'b0;
      RESET_N   = 1'b1;
      idle(5);
      status("post_rst2", 1'b0, 1'b0);
      iot("rrb_zero", 3'b010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      @(negedge CLK);
      #1;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
